// File: rtl/y86_regfile_sb_if.sv
// y86_regfile_sb_if: decode-side and write-back bus of the Y86-64 register file (master drives decode/write-back/debug inputs, slave returns selections, read data, stall, debug data)
interface y86_regfile_sb_if #(parameter int DATA_W = 64);
  logic              d_valid;
  logic [3:0]        d_icode, d_rA, d_rB;
  logic [3:0]        d_srcA, d_srcB, d_dstE, d_dstM;
  logic [DATA_W-1:0] d_valA, d_valB;
  logic              d_stall;
  logic              w_validE, w_validM;
  logic [3:0]        w_dstE, w_dstM;
  logic [DATA_W-1:0] w_valE, w_valM;
  logic [3:0]        dbg_idx;
  logic [DATA_W-1:0] dbg_data;
  modport master (
    output d_valid, d_icode, d_rA, d_rB, w_validE, w_validM, w_dstE, w_dstM, w_valE, w_valM, dbg_idx,
    input  d_srcA, d_srcB, d_dstE, d_dstM, d_valA, d_valB, d_stall, dbg_data
  );
  modport slave (
    input  d_valid, d_icode, d_rA, d_rB, w_validE, w_validM, w_dstE, w_dstM, w_valE, w_valM, dbg_idx,
    output d_srcA, d_srcB, d_dstE, d_dstM, d_valA, d_valB, d_stall, dbg_data
  );
endinterface

// File: rtl/y86_regfile_sb.sv
// y86_regfile_sb: Y86-64 register file with src/dst selection, pending-write scoreboard, stall and bypass (ports: clk, rst_n sync active-low, bus slave modport)
module y86_regfile_sb #(
  parameter int DATA_W       = 64,
  parameter int NREGS        = 15,
  parameter int SP_IDX       = 4,
  parameter int MAX_INFLIGHT = 3,
  parameter int BYPASS       = 1
) (
  input logic             clk,
  input logic             rst_n,
  y86_regfile_sb_if.slave bus
);
  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam int PW = CW + 2;
  localparam logic [3:0] F = 4'hF;
  localparam logic [3:0] SP = 4'(SP_IDX);
  localparam logic [CW-1:0] MAXC = CW'(MAX_INFLIGHT);
  localparam logic [CW-1:0] MAXM1 = CW'(MAX_INFLIGHT - 1);
  localparam logic BYP = BYPASS != 0;
  logic [DATA_W-1:0] regs_x [16];
  logic [CW-1:0]     pend_x [16];
  logic [1:0]        ret_x  [16];
  logic [15:0]       ok_x;
  logic              issue, haz_a, haz_b, full;
  assign issue = bus.d_valid && !bus.d_stall;
  always_comb begin
    bus.d_srcA = !bus.d_valid ? F : (bus.d_icode inside {4'h2, 4'h4, 4'h6, 4'hA}) ? bus.d_rA : (bus.d_icode inside {4'h9, 4'hB}) ? SP : F;
    bus.d_srcB = !bus.d_valid ? F : (bus.d_icode inside {4'h4, 4'h5, 4'h6}) ? bus.d_rB : (bus.d_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? SP : F;
    bus.d_dstE = !bus.d_valid ? F : (bus.d_icode inside {4'h2, 4'h3, 4'h6}) ? bus.d_rB : (bus.d_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? SP : F;
    bus.d_dstM = !bus.d_valid ? F : (bus.d_icode inside {4'h5, 4'hB}) ? bus.d_rA : F;
  end
  // Slots 0..15 exist so any 4-bit index can be looked up; unimplemented ones read as zero.
  for (genvar i = 0; i < 16; i++) begin : g_r
    if (i < NREGS) begin : g_on
      logic [DATA_W-1:0] r;
      logic [CW-1:0]     p;
      logic              we, wm;
      logic [1:0]        inc;
      logic [PW-1:0]     sum;
      assign we  = bus.w_validE && bus.w_dstE == 4'(i);
      assign wm  = bus.w_validM && bus.w_dstM == 4'(i);
      assign inc = {1'b0, issue && bus.d_dstE == 4'(i)} + {1'b0, issue && bus.d_dstM == 4'(i)};
      assign sum = PW'(p) + PW'(inc);
      assign ret_x[i]  = {1'b0, we} + {1'b0, wm};
      assign regs_x[i] = r;
      assign pend_x[i] = p;
      assign ok_x[i]   = 1'b1;
      // Retire of a non-pending register is a protocol error: clamp at zero.
      always_ff @(posedge clk)
        if (!rst_n) begin
          r <= '0;
          p <= '0;
        end else begin
          r <= wm ? bus.w_valM : we ? bus.w_valE : r;
          p <= sum < PW'(ret_x[i]) ? '0 : CW'(sum - PW'(ret_x[i]));
        end
    end else begin : g_off
      assign ret_x[i]  = '0;
      assign regs_x[i] = '0;
      assign pend_x[i] = '0;
      assign ok_x[i]   = 1'b0;
    end
  end
  // With bypass, writes retiring this cycle already cover the hazard.
  always_comb begin
    haz_a = bus.d_srcA != F && PW'(pend_x[bus.d_srcA]) > (BYP ? PW'(ret_x[bus.d_srcA]) : PW'(0));
    haz_b = bus.d_srcB != F && PW'(pend_x[bus.d_srcB]) > (BYP ? PW'(ret_x[bus.d_srcB]) : PW'(0));
    full  = (ok_x[bus.d_dstE] && pend_x[bus.d_dstE] == MAXC) || (ok_x[bus.d_dstM] && pend_x[bus.d_dstM] == MAXC) ||
            (ok_x[bus.d_dstE] && bus.d_dstE == bus.d_dstM && pend_x[bus.d_dstE] == MAXM1);
    bus.d_stall = bus.d_valid && (haz_a || haz_b || full);
    bus.d_valA = !ok_x[bus.d_srcA] ? '0 : (BYP && bus.w_validM && bus.w_dstM == bus.d_srcA) ? bus.w_valM :
                 (BYP && bus.w_validE && bus.w_dstE == bus.d_srcA) ? bus.w_valE : regs_x[bus.d_srcA];
    bus.d_valB = !ok_x[bus.d_srcB] ? '0 : (BYP && bus.w_validM && bus.w_dstM == bus.d_srcB) ? bus.w_valM :
                 (BYP && bus.w_validE && bus.w_dstE == bus.d_srcB) ? bus.w_valE : regs_x[bus.d_srcB];
    bus.dbg_data = regs_x[bus.dbg_idx];
  end
endmodule

// File: tb/tb_y86_regfile_sb.sv
// tb_y86_regfile_sb: scoreboard bench driving a bypassing and a non-bypassing register file with the same directed vectors
module tb_y86_regfile_sb;
  logic clk = 1'b0, rst_n = 1'b0;
  logic d_valid, w_validE, w_validM;
  logic [3:0] d_icode, d_rA, d_rB, w_dstE, w_dstM, dbg_idx;
  logic [63:0] w_valE, w_valM;
  int checks = 0, errors = 0;
  typedef struct {
    string n;
    logic [3:0] m;
    logic [63:0] va, vb, db;
    logic st;
    logic [63:0] va0;
    logic st0;
  } exp_t;
  exp_t q[$];
  y86_regfile_sb_if #(.DATA_W(64)) b1 ();
  y86_regfile_sb_if #(.DATA_W(64)) b0 ();
  assign b1.d_valid = d_valid;   assign b0.d_valid = d_valid;
  assign b1.d_icode = d_icode;   assign b0.d_icode = d_icode;
  assign b1.d_rA = d_rA;         assign b0.d_rA = d_rA;
  assign b1.d_rB = d_rB;         assign b0.d_rB = d_rB;
  assign b1.w_validE = w_validE; assign b0.w_validE = w_validE;
  assign b1.w_validM = w_validM; assign b0.w_validM = w_validM;
  assign b1.w_dstE = w_dstE;     assign b0.w_dstE = w_dstE;
  assign b1.w_dstM = w_dstM;     assign b0.w_dstM = w_dstM;
  assign b1.w_valE = w_valE;     assign b0.w_valE = w_valE;
  assign b1.w_valM = w_valM;     assign b0.w_valM = w_valM;
  assign b1.dbg_idx = dbg_idx;   assign b0.dbg_idx = dbg_idx;
  y86_regfile_sb #(.BYPASS(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  y86_regfile_sb #(.BYPASS(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  always #5 clk = ~clk;
  task automatic cmp(input string n, input logic [63:0] a, input logic [63:0] r);
    checks++;
    if (a !== r) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, r);
    end
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      automatic exp_t e = q.pop_front();
      if (e.m[0]) begin cmp({e.n, " byp valA"}, b1.d_valA, e.va); cmp({e.n, " nobyp valA"}, b0.d_valA, e.va0); end
      if (e.m[1]) begin cmp({e.n, " byp valB"}, b1.d_valB, e.vb); cmp({e.n, " nobyp valB"}, b0.d_valB, e.vb); end
      if (e.m[2]) begin cmp({e.n, " byp stall"}, 64'(b1.d_stall), 64'(e.st)); cmp({e.n, " nobyp stall"}, 64'(b0.d_stall), 64'(e.st0)); end
      if (e.m[3]) begin cmp({e.n, " byp dbg"}, b1.dbg_data, e.db); cmp({e.n, " nobyp dbg"}, b0.dbg_data, e.db); end
    end
  task automatic clr();
    d_valid = 0; d_icode = 0; d_rA = 4'hF; d_rB = 4'hF;
    w_validE = 0; w_validM = 0; w_dstE = 4'hF; w_dstM = 4'hF; w_valE = 0; w_valM = 0; dbg_idx = 0;
  endtask
  task automatic dec(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb);
    d_valid = 1; d_icode = ic; d_rA = ra; d_rB = rb;
  endtask
  task automatic ret_e(input logic [3:0] d, input logic [63:0] v);
    w_validE = 1; w_dstE = d; w_valE = v;
  endtask
  task automatic ret_m(input logic [3:0] d, input logic [63:0] v);
    w_validM = 1; w_dstM = d; w_valM = v;
  endtask
  task automatic tick();
    @(posedge clk); #1; clr();
  endtask
  task automatic stepx(input string n, input logic [3:0] m, input logic [63:0] va, input logic [63:0] vb,
                       input logic [63:0] db, input logic st, input logic [63:0] va0, input logic st0);
    q.push_back('{n, m, va, vb, db, st, va0, st0});
    tick();
  endtask
  task automatic step(input string n, input logic [3:0] m, input logic [63:0] va, input logic [63:0] vb,
                      input logic [63:0] db, input logic st);
    stepx(n, m, va, vb, db, st, va, st);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
  initial begin
    clr();
    tick(); tick();
    rst_n = 1;
    step("reset", 4'b1111, 0, 0, 0, 0);
    dec(3, 4'hF, 2);                  step("irmovq r2", 4'b0100, 0, 0, 0, 0);
    ret_e(2, 64'h1234); dbg_idx = 2;  step("wb r2 not yet visible", 4'b1100, 0, 0, 0, 0);
    dec(6, 2, 3); dbg_idx = 2;        step("opq reads r2", 4'b1111, 64'h1234, 0, 64'h1234, 0);
    dec(6, 3, 0);                     step("raw hazard r3", 4'b0100, 0, 0, 0, 1);
    dec(6, 3, 0); ret_e(3, 64'h55);   stepx("retire cycle r3", 4'b0111, 64'h55, 0, 0, 0, 0, 1);
    dec(6, 3, 0); dbg_idx = 3;        stepx("after retire r3", 4'b1101, 64'h55, 0, 64'h55, 1, 64'h55, 0);
    ret_e(0, 64'h77);                 step("retire r0", 4'b1100, 0, 0, 0, 0);
    dec(4'hB, 4, 4'hF); dbg_idx = 0;  step("popq issue", 4'b1111, 0, 0, 64'h77, 0);
    ret_e(4, 64'h108); ret_m(4, 64'hAA); dbg_idx = 4; step("popq retire", 4'b1100, 0, 0, 0, 0);
    dec(6, 4, 4'hF); dbg_idx = 4;     step("popq M wins", 4'b1101, 64'hAA, 0, 64'hAA, 0);
    for (int i = 0; i < 3; i++) begin
      dec(3, 4'hF, 1);                step("writer to r1", 4'b0100, 0, 0, 0, 0);
    end
    dec(3, 4'hF, 1);                  step("r1 inflight full", 4'b0100, 0, 0, 0, 1);
    dec(3, 4'hF, 1); ret_e(1, 64'h11); step("full during retire", 4'b0100, 0, 0, 0, 1);
    dec(3, 4'hF, 1);                  step("fourth accepted", 4'b0100, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      ret_e(1, 64'h12 + 64'(i));      tick();
    end
    dec(6, 1, 4'hF); dbg_idx = 1;     step("r1 drained", 4'b1101, 64'h14, 0, 64'h14, 0);
    dec(3, 4'hF, 5);                  step("r5 issue 1", 4'b0100, 0, 0, 0, 0);
    dec(3, 4'hF, 5); ret_e(5, 7);     step("r5 issue+retire", 4'b0100, 0, 0, 0, 0);
    dec(3, 4'hF, 5);                  step("r5 issue 2", 4'b0100, 0, 0, 0, 0);
    dec(6, 5, 4'hF); dbg_idx = 5;     step("r5 pending", 4'b1101, 7, 0, 7, 1);
    rst_n = 0; dec(3, 4'hF, 5); ret_e(5, 64'hEE); tick();
    rst_n = 1;
    dec(6, 5, 4'hF); dbg_idx = 5;     step("mid reset clears", 4'b1101, 0, 0, 0, 0);
    ret_e(5, 9);                      step("stray retire", 4'b0100, 0, 0, 0, 0);
    dec(6, 5, 4'hF); dbg_idx = 5;     step("pend saturated", 4'b1101, 9, 0, 9, 0);
    dec(0, 5, 5);                     step("halt rnone", 4'b0111, 0, 0, 0, 0);
    dec(1, 5, 5);                     step("nop rnone", 4'b0111, 0, 0, 0, 0);
    dec(7, 5, 5);                     step("jxx rnone", 4'b0111, 0, 0, 0, 0);
    dec(6, 4'hF, 4'hF); dbg_idx = 4'hF; step("index 15", 4'b1111, 0, 0, 0, 0);
    d_icode = 6; d_rA = 5; d_rB = 5;  step("d_valid low", 4'b0111, 0, 0, 0, 0);
    dec(6, 5, 5);                     step("no sb change", 4'b0111, 9, 9, 0, 0);
    tick(); tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/y86_regfile_sb.md
# y86_regfile_sb

Parametrised Y86-64 register file with integrated decode-source/destination selection, a per-register pending scoreboard and write-back bypass. It sits between fetch and execute in the pipelined processor. It replaces the single-cycle decode/write-back pairing with posedge writes, two write ports and hazard stall generation.

## Interface
- DATA_W, 64: register width.
- NREGS, 15: implemented registers, indices 0..NREGS-1 (max 15).
- SP_IDX, 4: stack-pointer index (%rsp).
- MAX_INFLIGHT, 3: pending writes tracked per register; counter width clog2(MAX_INFLIGHT+1).
- BYPASS, 1: 1 = same-cycle write data forwarded to read ports; 0 = no forwarding.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- d_valid  in  1  decode slot holds an instruction.
- d_icode  in  4  instruction code.
- d_rA, d_rB  in  4 each  register specifiers; 4'hF = RNONE.
- d_srcA, d_srcB, d_dstE, d_dstM  out  4 each  selected indices (combinational).
- d_valA, d_valB  out  DATA_W each  read data.
- d_stall  out  1  decode must hold this cycle.
- w_validE, w_validM  in  1 each  write-back ports active.
- w_dstE, w_dstM  in  4 each  write destinations; 4'hF = cancelled write (still retires).
- w_valE, w_valM  in  DATA_W each  write data.
- dbg_idx  in  4 / dbg_data  out  DATA_W  debug read, no bypass.

## Operation
- Selection (F = none): srcA = rA for icode 2,4,6,A; SP_IDX for 9,B. srcB = rB for 4,5,6; SP_IDX for 8,9,A,B. dstE = rB for 2,3,6; SP_IDX for 8,9,A,B. dstM = rA for 5,B. All other icodes: F. d_valid=0 forces all four to F.
- Read: index F or >= NREGS returns 0. Otherwise register contents. With BYPASS=1, a matching active write this cycle is returned instead; dstM beats dstE when both match.
- Write: a port writes its register on rising edge when valid and dst < NREGS. If w_dstE == w_dstM, both valid: valM is stored (popq %rsp semantics).
- Scoreboard: per-register counter pend[i]. An issue occurs when d_valid && !d_stall: increment pend[dstE] and pend[dstM] (twice if equal, index F ignored). Each valid write port retiring index i decrements pend[i]. Increments and decrements in the same cycle net out.
- Stall: d_stall = d_valid && (hazA || hazB || full).
  - hazX: srcX != F and effective pending > 0. Effective pending = pend minus same-cycle retires when BYPASS=1; raw pend when BYPASS=0.
  - full: dstE or dstM has pend == MAX_INFLIGHT, or pend == MAX_INFLIGHT-1 when dstE == dstM.
- A decrement of a zero counter is a protocol error: the counter saturates at 0 and the write still occurs.

## Timing
- Reset, rst_n low at a rising edge: all registers 0, all pend 0, writes and issues that cycle discarded. Outputs after reset: d_valA = d_valB = 0, d_stall = 0, dbg_data = 0.
- Reset asserted mid-operation clears in-flight scoreboard state. Retires arriving after reset saturate at 0.
- Read latency 0 (combinational). Write visible to non-bypassed reads the cycle after the edge.
- Stall is combinational from the current inputs and the state. No registered stall.

## Test plan
- Reset, then irmovq (icode 3, rB=2). Retire w_dstE=2, w_valE=0x1234. Next cycle OPq rA=2 -> d_valA=0x1234, dbg_idx=2 gives 0x1234.
- OPq rB=3 issued, then OPq rA=3 the next cycle with no retire -> d_stall=1. In the retire cycle, BYPASS=1 -> d_stall=0, d_valA = w_valE. BYPASS=0 -> stall one further cycle.
- popq rA=4 (SP_IDX): w_dstE=4 valE=0x108 and w_dstM=4 valM=0xAA on the same edge -> reg4=0xAA, pend[4] back to 0.
- Issue three writers to reg 1 without retire (MAX_INFLIGHT=3). A fourth issue -> d_stall=1. One retire -> the fourth issue is accepted.
- rst_n low mid-stream with pend[5]=2 and reg5=7 -> after the edge reg5=0, pend=0, d_stall=0. A stray retire to 5 leaves pend[5]=0.
- Reads of RNONE (halt, nop, jxx) and index 15 -> d_valA = d_valB = 0, no scoreboard change.
